// File: rtl/cfu_ctrl_pkg.sv
// Shared types for the CFU command sequencer: opcodes, control subops and FSM states.
package cfu_ctrl_pkg;

    typedef enum logic [2:0] {
        OP_CTRL       = 3'd0,
        OP_MAC4       = 3'd1,
        OP_SET_OFFSET = 3'd2
    } op_e;

    localparam logic [6:0] SUBOP_CLEAR    = 7'd0;
    localparam logic [6:0] SUBOP_READ_ACC = 7'd1;
    localparam logic [6:0] SUBOP_READ_ERR = 7'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/cfu_decode.sv
// Splits the CFU function_id into the 3-bit op and the 7-bit subop.
module cfu_decode (
    input  logic [9:0] function_id,
    output logic [2:0] op,
    output logic [6:0] subop
);

    assign op    = function_id[2:0];
    assign subop = function_id[9:3];

endmodule

// File: rtl/cfu_cmd_sequencer.sv
// CFU command sequencer: one response per command, multi-cycle int8 MAC over LANES lanes,
// sticky error flag for unknown ops. All outputs are registered.
module cfu_cmd_sequencer
    import cfu_ctrl_pkg::*;
#(
    parameter int LANES    = 4,
    parameter int OFFSET_W = 9
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [9:0]  cmd_payload_function_id,
    input  logic [31:0] cmd_payload_inputs_0,
    input  logic [31:0] cmd_payload_inputs_1,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_payload_outputs_0,
    output logic [1:0]  dbg_state
);

    // Handshake: a command transfers on a rising edge with cmd_valid && cmd_ready, a response
    // on rsp_valid && rsp_ready. Neither ready nor valid depends combinationally on the other side.

    localparam int CNT_W  = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int SUM_W  = ((OFFSET_W > 8) ? OFFSET_W : 8) + 1;
    localparam int PROD_W = SUM_W + 8;
    localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(LANES - 1);

    state_e                       state;
    logic [CNT_W-1:0]             lane_cnt;
    logic [31:0]                  in0_q;
    logic [31:0]                  in1_q;
    logic [31:0]                  acc_q;
    logic signed [OFFSET_W-1:0]   offset_q;
    logic                         err_q;

    logic [2:0]                   dec_op;
    logic [6:0]                   dec_subop;

    logic signed [7:0]            lane_a;
    logic signed [7:0]            lane_w;
    logic signed [SUM_W-1:0]      lane_sum;
    logic signed [PROD_W-1:0]     lane_prod;
    logic [31:0]                  acc_next;

    cfu_decode u_decode (
        .function_id (cmd_payload_function_id),
        .op          (dec_op),
        .subop       (dec_subop)
    );

    assign dbg_state = state;

    // Current lane term, taken from the operands latched at accept time.
    always_comb begin
        lane_a    = in0_q[{lane_cnt, 3'b000} +: 8];
        lane_w    = in1_q[{lane_cnt, 3'b000} +: 8];
        lane_sum  = SUM_W'(lane_a) + SUM_W'(offset_q);
        lane_prod = PROD_W'(lane_sum) * PROD_W'(lane_w);
        acc_next  = acc_q + 32'(lane_prod);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state                 <= ST_IDLE;
            lane_cnt              <= '0;
            in0_q                 <= '0;
            in1_q                 <= '0;
            acc_q                 <= '0;
            offset_q              <= '0;
            err_q                 <= 1'b0;
            cmd_ready             <= 1'b1;
            rsp_valid             <= 1'b0;
            rsp_payload_outputs_0 <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        in0_q     <= cmd_payload_inputs_0;
                        in1_q     <= cmd_payload_inputs_1;
                        cmd_ready <= 1'b0;
                        if (dec_op == OP_MAC4) begin
                            lane_cnt <= '0;
                            state    <= ST_EXEC;
                        end else begin
                            state     <= ST_RESP;
                            rsp_valid <= 1'b1;
                            rsp_payload_outputs_0 <= '0;
                            if (dec_op == OP_CTRL) begin
                                case (dec_subop)
                                    SUBOP_CLEAR: begin
                                        acc_q <= '0;
                                        err_q <= 1'b0;
                                    end
                                    SUBOP_READ_ACC: rsp_payload_outputs_0 <= acc_q;
                                    SUBOP_READ_ERR: rsp_payload_outputs_0 <= {31'b0, err_q};
                                    default:        err_q <= 1'b1;
                                endcase
                            end else if (dec_op == OP_SET_OFFSET) begin
                                offset_q <= cmd_payload_inputs_0[OFFSET_W-1:0];
                            end else begin
                                err_q <= 1'b1;
                            end
                        end
                    end
                end
                ST_EXEC: begin
                    acc_q    <= acc_next;
                    lane_cnt <= lane_cnt + 1'b1;
                    if (lane_cnt == LAST_LANE) begin
                        state                 <= ST_RESP;
                        rsp_valid             <= 1'b1;
                        rsp_payload_outputs_0 <= acc_next;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state     <= ST_IDLE;
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    rsp_valid <= 1'b0;
                    cmd_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cfu_cmd_sequencer.sv
// Bench for cfu_cmd_sequencer: directed scenarios plus random commands checked against
// an arithmetic model of the accumulator, offset and error flag.
module tb_cfu_cmd_sequencer;

    localparam int LANES = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [9:0]  cmd_payload_function_id;
    logic [31:0] cmd_payload_inputs_0;
    logic [31:0] cmd_payload_inputs_1;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_payload_outputs_0;
    logic [1:0]  dbg_state;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference state
    logic [31:0] m_acc;
    int          m_off;
    logic        m_err;

    cfu_cmd_sequencer #(.LANES(LANES), .OFFSET_W(9)) dut (
        .clk                     (clk),
        .reset                   (reset),
        .cmd_valid               (cmd_valid),
        .cmd_ready               (cmd_ready),
        .cmd_payload_function_id (cmd_payload_function_id),
        .cmd_payload_inputs_0    (cmd_payload_inputs_0),
        .cmd_payload_inputs_1    (cmd_payload_inputs_1),
        .rsp_valid               (rsp_valid),
        .rsp_ready               (rsp_ready),
        .rsp_payload_outputs_0   (rsp_payload_outputs_0),
        .dbg_state               (dbg_state)
    );

    // Clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "simulation time limit reached");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    endtask

    function automatic void model_reset();
        m_acc = 32'd0;
        m_off = 0;
        m_err = 1'b0;
    endfunction

    // Applies one command to the model; returns the response value and its latency.
    function automatic void model_cmd(input logic [9:0] fid, input logic [31:0] a,
                                      input logic [31:0] b, output logic [31:0] res,
                                      output int lat);
        int op;
        int subop;
        logic [8:0] off_bits;
        op    = int'(fid[2:0]);
        subop = int'(fid[9:3]);
        res   = 32'd0;
        lat   = 1;
        if (op == 1) begin
            for (int k = 0; k < LANES; k++) begin
                logic [7:0] ba;
                logic [7:0] bw;
                int term;
                ba    = a[8*k +: 8];
                bw    = b[8*k +: 8];
                term  = (int'($signed(ba)) + m_off) * int'($signed(bw));
                m_acc = m_acc + 32'(term);
            end
            res = m_acc;
            lat = LANES + 1;
        end else if (op == 2) begin
            off_bits = a[8:0];
            m_off    = int'($signed(off_bits));
        end else if (op == 0 && subop == 0) begin
            m_acc = 32'd0;
            m_err = 1'b0;
        end else if (op == 0 && subop == 1) begin
            res = m_acc;
        end else if (op == 0 && subop == 2) begin
            res = {31'b0, m_err};
        end else begin
            m_err = 1'b1;
        end
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    // Full command: accept, latency, optional stall with stability checks, handshake.
    task automatic do_cmd(input logic [9:0] fid, input logic [31:0] a, input logic [31:0] b,
                          input int stall, output logic [31:0] got);
        logic [31:0] exp;
        int exp_lat;
        int lat;
        model_cmd(fid, a, b, exp, exp_lat);
        check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        cmd_valid               = 1'b1;
        cmd_payload_function_id = fid;
        cmd_payload_inputs_0    = a;
        cmd_payload_inputs_1    = b;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_payload_inputs_0 = $urandom;
        cmd_payload_inputs_1 = $urandom;
        check("busy_cmd_ready", 32'(cmd_ready), 32'd0);
        lat = 1;
        while (!rsp_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("latency", 32'(lat), 32'(exp_lat));
        check("result", rsp_payload_outputs_0, exp);
        got = rsp_payload_outputs_0;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check("hold_valid", 32'(rsp_valid), 32'd1);
            check("hold_data", rsp_payload_outputs_0, exp);
            check("hold_cmd_ready", 32'(cmd_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("post_hs_rsp_valid", 32'(rsp_valid), 32'd0);
        check("post_hs_cmd_ready", 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        logic [31:0] got;
        logic [31:0] exp_a;
        logic [31:0] exp_b;
        int lat_a;
        int lat_b;
        reset = 1'b1;
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        cmd_payload_function_id = '0;
        cmd_payload_inputs_0 = '0;
        cmd_payload_inputs_1 = '0;

        apply_reset();
        check("reset_cmd_ready", 32'(cmd_ready), 32'd1);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_payload", rsp_payload_outputs_0, 32'd0);
        do_cmd(10'h008, 32'd0, 32'd0, 0, got);
        check("read_acc_after_reset", got, 32'd0);

        // Offset 128, unit weights
        do_cmd(10'h002, 32'd128, 32'd0, 0, got);
        do_cmd(10'h001, 32'h01020304, 32'h01010101, 0, got);
        check("mac_offset128", got, 32'd522);
        do_cmd(10'h008, 32'd0, 32'd0, 1, got);
        check("read_acc_522", got, 32'd522);

        // Negative activations, zero offset
        do_cmd(10'h000, 32'd0, 32'd0, 0, got);
        do_cmd(10'h002, 32'd0, 32'd0, 0, got);
        do_cmd(10'h001, 32'hFFFFFFFF, 32'h7F7F7F7F, 2, got);
        check("mac_negative", got, 32'hFFFFFE04);

        // Backpressure with the next command already presented
        model_cmd(10'h008, 32'd0, 32'd0, exp_a, lat_a);
        model_cmd(10'h010, 32'd0, 32'd0, exp_b, lat_b);
        cmd_valid = 1'b1;
        cmd_payload_function_id = 10'h008;
        @(negedge clk);
        cmd_payload_function_id = 10'h010;
        for (int i = 0; i < 3; i++) begin
            check("bp_valid", 32'(rsp_valid), 32'd1);
            check("bp_data", rsp_payload_outputs_0, exp_a);
            check("bp_cmd_ready", 32'(cmd_ready), 32'd0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("bp_after_hs_ready", 32'(cmd_ready), 32'd1);
        check("bp_after_hs_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("bp_next_valid", 32'(rsp_valid), 32'd1);
        check("bp_next_data", rsp_payload_outputs_0, exp_b);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;

        // Sticky error flag
        do_cmd(10'h005, 32'h12345678, 32'h9ABCDEF0, 0, got);
        check("illegal_op_result", got, 32'd0);
        do_cmd(10'h010, 32'd0, 32'd0, 0, got);
        check("read_err_set", got, 32'd1);
        do_cmd(10'h000, 32'd0, 32'd0, 0, got);
        do_cmd(10'h010, 32'd0, 32'd0, 0, got);
        check("read_err_cleared", got, 32'd0);

        // Reset during EXEC lane 2
        do_cmd(10'h002, 32'd37, 32'd0, 0, got);
        do_cmd(10'h001, 32'h05060708, 32'h02030405, 0, got);
        cmd_valid = 1'b1;
        cmd_payload_function_id = 10'h001;
        cmd_payload_inputs_0 = 32'h11223344;
        cmd_payload_inputs_1 = 32'h55667788;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        check("exec_reset_cmd_ready", 32'(cmd_ready), 32'd1);
        check("exec_reset_rsp_valid", 32'(rsp_valid), 32'd0);
        do_cmd(10'h008, 32'd0, 32'd0, 0, got);
        check("exec_reset_acc", got, 32'd0);
        do_cmd(10'h001, 32'h01010101, 32'h01010101, 0, got);
        check("offset_reset_mac", got, 32'd4);

        // Random commands
        for (int n = 0; n < 80; n++) begin
            int r;
            logic [2:0] op;
            logic [6:0] subop;
            r = int'($urandom_range(0, 9));
            if (r <= 3) begin
                op = 3'd1;
                subop = 7'($urandom);
            end else if (r <= 5) begin
                op = 3'd0;
                subop = 7'($urandom_range(0, 3));
            end else if (r <= 7) begin
                op = 3'd2;
                subop = 7'($urandom);
            end else begin
                op = 3'($urandom_range(3, 7));
                subop = 7'($urandom);
            end
            do_cmd({subop, op}, $urandom, $urandom, int'($urandom_range(0, 3)), got);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/cfu_cmd_sequencer.md
# cfu_cmd_sequencer

Command sequencer for the image-classification CFU. It accepts CPU custom-instruction commands over the valid/ready CFU bus and splits `function_id` into op/subop via `cfu_decode`. It dispatches each command to a 4-lane int8 multiply-accumulate datapath or to configuration registers, then returns exactly one response per command with full backpressure.

## Interface
- `LANES`, 4, int8 lanes per MAC4 command (1..4; lane i = byte i of the inputs)
- `OFFSET_W`, 9, width of the signed input-offset register
- `clk`  in  1  clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high reset
- `cmd_valid`  in  1  command present
- `cmd_ready`  out  1  sequencer can accept a command
- `cmd_payload_function_id`  in  10  [2:0]=op, [9:3]=subop
- `cmd_payload_inputs_0`  in  32  operand 0 (activations / config value)
- `cmd_payload_inputs_1`  in  32  operand 1 (weights)
- `rsp_valid`  out  1  response present
- `rsp_ready`  in  1  CPU accepts response
- `rsp_payload_outputs_0`  out  32  result

## Operation
- States: IDLE, EXEC, RESP.
- IDLE: `cmd_ready`=1. On `cmd_valid`, latch inputs and decoded op/subop, then:
  - op=1 → EXEC, lane counter=0.
  - Any other op → RESP with result computed that cycle.
- EXEC: `cmd_ready`=0. Each cycle, lane k: acc += sext32((sext(in0[8k+7:8k]) + offset) * sext(in1[8k+7:8k])). Counter increments. After lane LANES-1 → RESP, result = new acc.
- RESP: `rsp_valid`=1, `cmd_ready`=0. Result is held stable until `rsp_valid && rsp_ready`, then → IDLE.
- Ops:
  - op0 subop0 CLEAR: acc=0, err=0, result 0.
  - op0 subop1 READ_ACC: result acc.
  - op0 subop2 READ_ERR: result {31'b0, err}.
  - op1 MAC4: any subop.
  - op2 SET_OFFSET: offset = in0[OFFSET_W-1:0] signed, result 0.
  - Op 3..7, or op0 with subop>2: result 0, err set sticky.
- Width rules:
  - Lane term: 10-bit signed sum × 8-bit signed = 18-bit signed product.
  - Accumulator is 32-bit two's complement and wraps mod 2^32 with no saturation.
- Reset (any state, including mid-EXEC or with response pending): next cycle IDLE, acc=0, offset=0, err=0, lane counter=0. The pending response is dropped.
- `cmd_valid` outside IDLE is ignored; the command is not consumed.

## Timing
- Reset values: `cmd_ready`=1, `rsp_valid`=0, `rsp_payload_outputs_0`=0.
- Non-MAC op accepted at cycle N → `rsp_valid` at N+1.
- MAC4 accepted at N → EXEC cycles N+1..N+LANES → `rsp_valid` at N+LANES+1 (N+5 by default).
- Response handshake at cycle M → `cmd_ready`=1 at M+1. Back-to-back throughput is therefore one command per 2 cycles (non-MAC).
- Payload changes only on the IDLE/EXEC → RESP transition.
- No combinational path from `rsp_ready` or `cmd_valid` to any output.

## Structure
- Package `cfu_ctrl_pkg`:
  - op enum (OP_CTRL=0, OP_MAC4=1, OP_SET_OFFSET=2)
  - ctrl subop constants (CLEAR=0, READ_ACC=1, READ_ERR=2)
  - state enum
- Sub-module: existing `cfu_decode` for the op/subop split.
- The lane MAC is inline; a separate module is not warranted.

## Test plan
- Reset then READ_ACC (function_id=10'h008): `cmd_ready`=1 and `rsp_valid`=0 after reset; `rsp_valid` at N+1 with output 0.
- SET_OFFSET in0=128, then MAC4 in0=0x01020304, in1=0x01010101: `rsp_valid` at N+5, output 522; READ_ACC returns 522.
- CLEAR, offset 0, MAC4 in0=0xFFFFFFFF, in1=0x7F7F7F7F: output 0xFFFFFE04 (−508).
- Backpressure: hold `rsp_ready`=0 for 3 cycles with `cmd_valid`=1 and a new command presented:
  - `rsp_valid`, payload and `cmd_ready`=0 stay stable.
  - The new command is accepted only in the cycle after the handshake.
- Illegal op 5 → output 0; READ_ERR returns 1; after CLEAR, READ_ERR returns 0.
- Assert `reset` during EXEC lane 2: next cycle `cmd_ready`=1, `rsp_valid`=0; READ_ACC returns 0.
